// File: rtl/bus_router_arb.sv
// Purpose: arbitrates DRVRS source FIFOs and routes each packet by header ID to one device or broadcasts to all others.
// Latency: pop at cycle N, push at N+1 when unblocked; one packet per 2 cycles at best.
// Backpressure: waits in SEND until no target is full; drops (err, drop_cnt) after TIMEOUT blocked cycles or on invalid ID.
module bus_router_arb #(
   parameter int              DRVRS     = 5,
   parameter int              PCKG_SZ   = 32,
   parameter int              ID_W      = 8,
   parameter logic [ID_W-1:0] BROADCAST = ID_W'(8'hFF),
   parameter int              TIMEOUT   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     arb_mode,
   input  logic [DRVRS-1:0]         pndng,
   input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
   input  logic [DRVRS-1:0]         full,
   output logic [DRVRS-1:0]         pop,
   output logic [DRVRS-1:0]         push,
   output logic [PCKG_SZ-1:0]       D_push,
   output logic                     busy,
   output logic                     err,
   output logic [15:0]              drop_cnt
);

   localparam int IDX_W  = (DRVRS > 1) ? $clog2(DRVRS) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PCKG_SZ-1:0]  pkt_q, pkt_d;
   logic [DRVRS-1:0]    mask_q, mask_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                inv_q, inv_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;
   logic [PCKG_SZ-1:0]  dpush_q;

   logic [IDX_W-1:0]    rr_win, fp_win, win;
   logic                rr_found;
   logic [IDX_W-1:0]    cand;
   int                  idx;
   logic [PCKG_SZ-1:0]  head_w;
   logic [ID_W-1:0]     hdr;
   logic                hdr_ok;
   logic                cap;
   logic                drop_send;

   // Round-robin search: first pending device above rr_ptr, wrapping around.
   always_comb begin
      rr_win   = '0;
      rr_found = 1'b0;
      idx      = 0;
      cand     = '0;
      for (int k = 1; k <= DRVRS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= DRVRS) idx = idx - DRVRS;
         cand = IDX_W'(idx);
         if (!rr_found && pndng[cand]) begin
            rr_found = 1'b1;
            rr_win   = cand;
         end
      end
   end

   // Fixed priority: lowest pending index wins.
   always_comb begin
      fp_win = '0;
      for (int i = DRVRS - 1; i >= 0; i--) begin
         if (pndng[i]) fp_win = IDX_W'(i);
      end
   end

   // Header decode of the winner's head word, registered on capture.
   always_comb begin
      win    = arb_mode ? fp_win : rr_win;
      head_w = D_pop[win*PCKG_SZ +: PCKG_SZ];
      hdr    = head_w[PCKG_SZ-1 -: ID_W];
      hdr_ok = 1'b1;
      mask_d = mask_q;
      if (hdr == BROADCAST) begin
         mask_d = ~(DRVRS'(1) << win);
      end else if (int'(hdr) < DRVRS) begin
         mask_d = DRVRS'(1) << hdr;
      end else begin
         hdr_ok = 1'b0;
      end
   end

   // Next-state and output logic; pop is gated while reset is held so nothing dequeues under reset.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      pkt_d      = pkt_q;
      wait_d     = wait_q;
      inv_d      = 1'b0;
      drop_cnt_d = drop_cnt_q;
      pop        = '0;
      push       = '0;
      cap        = 1'b0;
      drop_send  = 1'b0;
      case (state_q)
         IDLE: begin
            if (reset && (|pndng)) begin
               cap         = 1'b1;
               pop[win]    = 1'b1;
               pkt_d       = head_w;
               wait_d      = '0;
               inv_d       = ~hdr_ok;
               state_d     = hdr_ok ? SEND : IDLE;
               if (!arb_mode) rr_ptr_d = win;
            end
         end
         SEND: begin
            if ((mask_q & full) == '0) begin
               push    = mask_q;
               state_d = IDLE;
            end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
               drop_send = 1'b1;
               state_d   = IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (((cap && !hdr_ok) || drop_send) && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= IDX_W'(DRVRS - 1);
         pkt_q      <= '0;
         mask_q     <= '0;
         wait_q     <= '0;
         inv_q      <= 1'b0;
         drop_cnt_q <= '0;
         dpush_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         pkt_q      <= pkt_d;
         wait_q     <= wait_d;
         inv_q      <= inv_d;
         drop_cnt_q <= drop_cnt_d;
         if (cap) mask_q <= mask_d;
         if (|push) dpush_q <= pkt_q;
      end
   end

   // D_push shows the packet during push and otherwise holds the last pushed word.
   assign D_push   = (|push) ? pkt_q : dpush_q;
   assign busy     = (state_q == SEND);
   assign err      = inv_q | drop_send;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/bus_router_arb.md
Name: bus_router_arb

Overview:
- Parametrised successor to the bs_gnrtr_n_rbtr bus generator/arbiter.
- Arbitrates among DRVRS device source FIFOs (pndng/pop/D_pop), decodes the destination ID in each packet's header, and pushes the packet onto a shared D_push bus to one device or, for broadcast, to all other devices.
- New relative to the previous generation: selectable round-robin/fixed-priority arbitration, per-destination backpressure (full), a stall timeout with drop, invalid-ID detection, and a drop counter.

Parameters:
- DRVRS, 5, number of attached devices (2..16).
- PCKG_SZ, 32, packet width in bits (ID_W+1..128).
- ID_W, 8, width of the destination-ID header field, located at bits [PCKG_SZ-1 -: ID_W].
- BROADCAST, 8'hFF, header value that selects broadcast.
- TIMEOUT, 16, maximum cycles spent in SEND waiting on full before the packet is dropped (>=2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- arb_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled in IDLE only.
- pndng  in  DRVRS  device i source FIFO non-empty.
- D_pop  in  DRVRS*PCKG_SZ  FWFT head word of each device FIFO; slice i = [i*PCKG_SZ +: PCKG_SZ].
- full  in  DRVRS  device i destination FIFO cannot accept a push.
- pop  out  DRVRS  one-hot, 1-cycle pulse; dequeues the winner's FIFO head.
- push  out  DRVRS  1-cycle push strobe per destination; multi-hot for broadcast.
- D_push  out  PCKG_SZ  shared data bus; valid only while any push bit is high.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  1-cycle pulse on any drop.
- drop_cnt  out  16  saturating count of dropped packets.

Behaviour:
- Reset (async assert, sync release): state = IDLE; pop = push = 0; D_push = 0; busy = 0; err = 0; drop_cnt = 0; rr_ptr = DRVRS-1, so device 0 is favoured first. A packet already captured when reset asserts is discarded and not counted.
- FSM states: IDLE, SEND.
- IDLE, when any pndng is high:
  - Select winner w. Round-robin: first set pndng searching upward from rr_ptr+1 with wrap. Fixed priority: lowest set index.
  - Assert pop[w] for that cycle and capture D_pop slice w and source index w into registers.
  - Round-robin mode updates rr_ptr = w. Fixed-priority mode leaves rr_ptr unchanged.
- IDLE, when no pndng is high: outputs idle, state unchanged.
- Decode of the captured header h, registered at capture:
  - h == BROADCAST: target mask = all devices except source.
  - h < DRVRS: target mask = one-hot h. Self-addressing (h == source) is legal.
  - Otherwise the ID is invalid.
- Invalid ID: the next cycle stays in IDLE (a new arbitration may occur that same cycle), err = 1 for one cycle, drop_cnt increments.
- Valid ID: next state SEND; busy = 1; the wait counter clears to 0.
- SEND: if (target mask & full) == 0, then in that same cycle push = target mask and D_push = captured packet, and the next state is IDLE. Otherwise wait_cnt increments.
- SEND timeout: if wait_cnt reaches TIMEOUT-1 with targets still blocked, no push occurs, err pulses, drop_cnt increments, and the next state is IDLE.
- Broadcast is all-or-nothing: there is no partial delivery, and the block waits until every target is not full.
- Latency with no backpressure: pop at cycle N, push at cycle N+1, next pop earliest at N+2. Throughput is one packet per 2 cycles.
- pop is never asserted while in SEND; pndng changes during SEND do not affect the packet in flight.
- drop_cnt saturates at 16'hFFFF; err still pulses on every drop.
- push and pop are never high in the same cycle.
- D_push holds its last value when push = 0. The verifier checks D_push only on push.
- arb_mode changes take effect at the next arbitration; rr_ptr is retained across a mode switch.

Test Plan:
1. Reset, then pndng = 5'b00001 with D_pop[0] = 32'h03_00ABCD, full = 0 -> pop = 00001 at N; push = 01000 and D_push = 32'h0300ABCD at N+1; busy high at N+1 only.
2. Round-robin, pndng = 5'b11111 held, each packet addressed to device 0 -> pop order 0,1,2,3,4,0, one pop every 2 cycles. Then arb_mode = 1 with the same stimulus -> pop always = 00001.
3. Device 2 sends header 8'hFF -> push = 11011 in a single cycle. With full[4] = 1 for 3 cycles, then released -> push delayed exactly 3 cycles, no partial push, err = 0.
4. Header 8'h07 with DRVRS = 5 -> no push, err pulse one cycle after pop, drop_cnt = 1, next arbitration allowed in that same cycle.
5. Destination 1 with full[1] held high and TIMEOUT = 16 -> push never asserts, err pulses 16 cycles after pop, drop_cnt increments by 1, FSM returns to IDLE and serves the next pending device.
6. Assert reset (low) while in SEND with full blocking -> outputs zero immediately. After release, that packet is never pushed, drop_cnt = 0, and first grant goes to the lowest pending device.
